// File: rtl/e3_pkg.sv
// Shared constants and the Excess-3 to BCD decode helper for the serial collector.
package e3_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  E3_OFFSET = 4'd3;
  localparam logic [3:0]  E3_MIN    = 4'd3;
  localparam logic [3:0]  E3_MAX    = 4'd12;
  localparam logic [3:0]  BCD_ERR   = 4'hF;

  // Returns {err, digit}; illegal codes map to BCD_ERR so the subtract never wraps.
  function automatic logic [4:0] e3_decode(input logic [3:0] code);
    logic err;
    err = (code < E3_MIN) || (code > E3_MAX);
    return {err, (err ? BCD_ERR : code - E3_OFFSET)};
  endfunction

endpackage

// File: rtl/e3_frame_deser.sv
// Frames the LSB-first serial E3 stream into 4-bit codes and decodes each one.
module e3_frame_deser
  import e3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d_in,
  output logic       frame_end,
  output logic [3:0] dec_digit,
  output logic       dec_err,
  output logic [3:0] e3_code,
  output logic [3:0] bcd_digit,
  output logic       code_err,
  output logic       digit_valid
);

  logic [1:0] bit_cnt_q;
  logic [3:0] sr_q;
  logic [3:0] code;
  logic [3:0] e3_code_q;
  logic [3:0] bcd_digit_q;
  logic       code_err_q;
  logic       digit_valid_q;

  // The code completing on this edge, visible to the word assembler in the same cycle.
  always_comb begin
    code                 = {d_in, sr_q[3:1]};
    frame_end            = (bit_cnt_q == 2'd3);
    {dec_err, dec_digit} = e3_decode(code);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= 2'd0;
      sr_q          <= 4'd0;
      e3_code_q     <= 4'd0;
      bcd_digit_q   <= 4'd0;
      code_err_q    <= 1'b0;
      digit_valid_q <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_q + 2'd1;
      sr_q          <= code;
      digit_valid_q <= frame_end;
      if (frame_end) begin
        e3_code_q   <= code;
        bcd_digit_q <= dec_digit;
        code_err_q  <= dec_err;
      end
    end
  end

  assign e3_code     = e3_code_q;
  assign bcd_digit   = bcd_digit_q;
  assign code_err    = code_err_q;
  assign digit_valid = digit_valid_q;

endmodule

// File: rtl/e3_serial_collector.sv
// Packs decoded BCD digits into NUM_DIGITS-wide words with a valid/ack handshake.
module e3_serial_collector
  import e3_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_in,
  output logic [3:0]                    e3_code,
  output logic [3:0]                    bcd_digit,
  output logic                          digit_valid,
  output logic                          code_err,
  output logic [DIGIT_W*NUM_DIGITS-1:0] word_out,
  output logic                          word_valid,
  output logic                          word_err,
  input  logic                          word_ack,
  output logic                          overrun
);

  localparam int unsigned WordW = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CntW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(NUM_DIGITS - 1);

  logic             frame_end;
  logic [3:0]       dec_digit;
  logic             dec_err;
  logic [CntW-1:0]  digit_cnt_q, digit_cnt_d;
  logic [WordW-1:0] asm_q, asm_d, asm_cur;
  logic             acc_err_q, acc_err_d;
  logic [WordW-1:0] word_out_q, word_out_d;
  logic             word_err_q, word_err_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;

  e3_frame_deser u_deser (
    .clk         (clk),
    .reset       (reset),
    .d_in        (d_in),
    .frame_end   (frame_end),
    .dec_digit   (dec_digit),
    .dec_err     (dec_err),
    .e3_code     (e3_code),
    .bcd_digit   (bcd_digit),
    .code_err    (code_err),
    .digit_valid (digit_valid)
  );

  always_comb begin
    asm_d        = asm_q;
    acc_err_d    = acc_err_q;
    digit_cnt_d  = digit_cnt_q;
    word_out_d   = word_out_q;
    word_err_d   = word_err_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;
    asm_cur      = asm_q;
    asm_cur[digit_cnt_q*DIGIT_W +: DIGIT_W] = dec_digit;

    if (word_ack && word_valid_q) begin
      word_valid_d = 1'b0;
    end

    if (frame_end) begin
      if (digit_cnt_q == LastDigit) begin
        digit_cnt_d = '0;
        asm_d       = '0;
        acc_err_d   = 1'b0;
        // An ack on the completion edge frees the slot for the new word.
        if (!word_valid_q || word_ack) begin
          word_out_d   = asm_cur;
          word_err_d   = acc_err_q | dec_err;
          word_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        digit_cnt_d = digit_cnt_q + CntW'(1);
        asm_d       = asm_cur;
        acc_err_d   = acc_err_q | dec_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_cnt_q  <= '0;
      asm_q        <= '0;
      acc_err_q    <= 1'b0;
      word_out_q   <= '0;
      word_err_q   <= 1'b0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      digit_cnt_q  <= digit_cnt_d;
      asm_q        <= asm_d;
      acc_err_q    <= acc_err_d;
      word_out_q   <= word_out_d;
      word_err_q   <= word_err_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_err   = word_err_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/e3_serial_collector.md
Name: e3_serial_collector

Overview:
- Downstream consumer of the bit-serial BCD-to-Excess-3 Mealy converter output.
- Frames the LSB-first serial E3 stream into 4-bit codes and validates each code (legal E3 = 3..12).
- Decodes each code back to a BCD digit and packs NUM_DIGITS digits into a parallel word, offered to the next stage with a valid/ack handshake.
- Frame alignment is by reset only; the converter has no sync marker, and both blocks share one reset net.

Parameters:
NUM_DIGITS, 4, BCD digits per assembled word (legal range 1..8)

Ports:
clk  input  1  system clock; all sampling on rising edge
reset  input  1  asynchronous, active-high; same net as the converter's reset
d_in  input  1  serial E3 bit, LSB first, one bit per clk (converter d_out)
e3_code  output  4  last complete E3 code, registered
bcd_digit  output  4  e3_code-3 when legal, 4'hF when illegal
digit_valid  output  1  one-cycle pulse: e3_code/bcd_digit updated
code_err  output  1  qualifies digit_valid: code <3 or >12
word_out  output  4*NUM_DIGITS  packed BCD word; first-received digit in bits [3:0]
word_valid  output  1  word_out holds an un-acked word
word_err  output  1  at least one digit of word_out had code_err
word_ack  input  1  consumer accepts word_out on a clk edge where word_valid=1
overrun  output  1  sticky: a word completed while the previous was un-acked

Behaviour:
- Reset (async assert, sync release), all cleared to 0: bit_cnt, shift reg, e3_code, bcd_digit, digit_valid, code_err, digit_cnt, word_out, word_valid, word_err, overrun.
- Bit framing: bit_cnt is 2 bits and increments on every clk edge, wrapping 3->0. There is no enable; the converter advances every clock.
  - The first rising edge after reset release samples bit 0.
  - While reset is asserted, nothing is sampled.
- Shift: sr <= {d_in, sr[3:1]} on every edge.
  - On the edge where bit_cnt==3, code = {d_in, sr[3:1]}.
- Digit stage, on the bit_cnt==3 edge (the 4th bit):
  - e3_code <= code.
  - code_err <= (code<3) or (code>12).
  - bcd_digit <= code_err ? 4'hF : code-3 (4-bit subtract; never wraps because illegal codes are substituted).
  - digit_valid <= 1, and is 0 on all other edges.
  - Latency: digit_valid is high in the cycle after the 4th bit's edge.
- Word assembly, on the same edge:
  - The digit is written to nibble digit_cnt of the assembly buffer.
  - The error accumulator ORs in code_err.
  - digit_cnt increments, wrapping at NUM_DIGITS-1 -> 0.
- Word completion (digit_cnt==NUM_DIGITS-1 on that edge):
  - If word_valid==0, or word_ack==1 on the same edge: word_out <= assembled word including the current digit; word_err <= accumulated | code_err; word_valid <= 1.
  - Else (un-acked word pending): the new word is dropped, the old word_out/word_err are kept, overrun <= 1.
  - In all cases the assembly buffer and accumulator restart clear for the next word.
- Handshake:
  - word_ack with word_valid=1 and no completion on that edge: word_valid <= 0; word_out is held, don't-care.
  - word_ack while word_valid=0 is ignored.
- overrun is cleared only by reset.
- Reset mid-frame or mid-word: immediate asynchronous clear; a partial code or word is discarded. Framing restarts at bit 0 on release, consistent with the converter's reset to its initial state.
- Illegal codes do not disturb framing or digit_cnt; the error is reported and counting continues.

Decomposition:
- Package e3_pkg:
  - constants E3_OFFSET=3, E3_MIN=3, E3_MAX=12, BCD_ERR=4'hF, DIGIT_W=4
  - function e3_decode(code) returning {err, digit}
- Sub-module e3_frame_deser: bit_cnt, shift reg, digit stage. Outputs e3_code, bcd_digit, code_err, digit_valid.
- Top e3_serial_collector: instantiates e3_frame_deser and contains word assembly, handshake and overrun.

Test Plan:
- Reset release, then serial 0,0,0,1 (E3 8): digit_valid pulses once in cycle 5 with e3_code=8, bcd_digit=5, code_err=0.
- Codes 4,5,6,7 LSB-first (16 bits), word_ack tied 0: word_out=16'h4321, word_valid=1 from cycle 17, word_err=0, overrun=0.
- Illegal code 0000 then 1111 (as digits 1-2 of a word), then codes 3,12: two code_err pulses, bcd_digit=F each time, final word_out=16'h90FF, word_err=1.
- Two consecutive words, no ack: first word_out kept, second dropped, overrun=1 and stays 1.
- Ack asserted exactly on the completion edge of the second word: word_valid stays 1, word_out = second word, overrun=0.
- Reset asserted after 2 bits of a code, then released and 4 bits of code 9 sent: all outputs clear asynchronously; next digit_valid shows bcd_digit=6; digit_cnt restarts at nibble 0.
